// File: rtl/systolic_array_ctrl_if.sv
// Signal bundle between the job issuer, the systolic-array sequencer and the array's buffers.
// master: job issuer / observer side; slave: the sequencer.
interface systolic_array_ctrl_if #(
    parameter int ARRAY_M = 16,
    parameter int ADDR_W  = 10,
    parameter int VEC_W   = 10
);
    // cfg_start is a single-cycle request with no ready: it is taken only while busy is low,
    // otherwise it is dropped; busy is the back-pressure indication for the issuer.
    logic               cfg_start;
    logic [ADDR_W-1:0]  cfg_wgt_base;
    logic [ADDR_W-1:0]  cfg_inp_base;
    logic [VEC_W-1:0]   cfg_num_vec;

    logic               busy;
    logic               done;
    logic               wgt_rd_req;
    logic [ADDR_W-1:0]  wgt_rd_addr;
    logic               inp_rd_req;
    logic [ADDR_W-1:0]  inp_rd_addr;
    logic [ARRAY_M-1:0] b_path_en;
    logic [ARRAY_M-1:0] b_en;
    logic               out_valid;
    logic [VEC_W-1:0]   out_idx;
    logic [2:0]         dbg_state;

    modport master (
        output cfg_start, cfg_wgt_base, cfg_inp_base, cfg_num_vec,
        input  busy, done, wgt_rd_req, wgt_rd_addr, inp_rd_req, inp_rd_addr,
               b_path_en, b_en, out_valid, out_idx, dbg_state
    );

    modport slave (
        input  cfg_start, cfg_wgt_base, cfg_inp_base, cfg_num_vec,
        output busy, done, wgt_rd_req, wgt_rd_addr, inp_rd_req, inp_rd_addr,
               b_path_en, b_en, out_valid, out_idx, dbg_state
    );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for the weight-stationary systolic array: weight load, commit, activation
// streaming and result tracking until the array has drained.
module systolic_array_ctrl #(
    parameter int ARRAY_M  = 16,
    parameter int ARRAY_N  = 16,
    parameter int ADDR_W   = 10,
    parameter int VEC_W    = 10,
    parameter int PIPE_LAT = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    systolic_array_ctrl_if.slave bus
);
    localparam int               CNT_W    = $clog2(ARRAY_M + 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ARRAY_M - 1);

    if (ARRAY_M < 1 || ARRAY_N < 1 || PIPE_LAT < 1) begin : g_param_check
        $error("systolic_array_ctrl: ARRAY_M, ARRAY_N and PIPE_LAT must all be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WLOAD   = 3'd1,
        S_WCOMMIT = 3'd2,
        S_COMPUTE = 3'd3,
        S_DRAIN   = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic [VEC_W-1:0]   vcnt_q, vcnt_d;
    logic               b_en_q, b_en_d;

    logic [ADDR_W-1:0]  wgt_base_q;
    logic [ADDR_W-1:0]  inp_base_q;
    logic [VEC_W-1:0]   num_vec_q;

    logic               cfg_latch;
    logic               wgt_req;
    logic               inp_req;
    logic               shift_en;
    logic               done;
    logic               pipe_empty;

    // Result tracker: bit i of pv_q set means a vector issued i+1 cycles ago is in flight.
    logic [PIPE_LAT:0]  pv_q;
    logic [VEC_W-1:0]   pidx_q [PIPE_LAT+1];

    assign pipe_empty = ~|pv_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            vcnt_q  <= '0;
            b_en_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            vcnt_q  <= vcnt_d;
            b_en_q  <= b_en_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wgt_base_q <= '0;
            inp_base_q <= '0;
            num_vec_q  <= '0;
        end else if (cfg_latch) begin
            wgt_base_q <= bus.cfg_wgt_base;
            inp_base_q <= bus.cfg_inp_base;
            num_vec_q  <= bus.cfg_num_vec;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        vcnt_d    = vcnt_q;
        cfg_latch = 1'b0;
        wgt_req   = 1'b0;
        inp_req   = 1'b0;
        shift_en  = 1'b0;
        done      = 1'b0;
        // Commit follows the final shift by exactly one cycle, whatever state comes next.
        b_en_d    = (state_q == S_WCOMMIT);

        unique case (state_q)
            S_IDLE: begin
                if (bus.cfg_start) begin
                    cfg_latch = 1'b1;
                    wcnt_d    = '0;
                    state_d   = S_WLOAD;
                end
            end
            S_WLOAD: begin
                wgt_req  = 1'b1;
                // Read data lags the strobe by one cycle, so shifting starts one cycle in.
                shift_en = (wcnt_q != '0);
                if (wcnt_q == ROW_LAST) begin
                    state_d = S_WCOMMIT;
                end else begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                end
            end
            S_WCOMMIT: begin
                shift_en = 1'b1;
                wcnt_d   = '0;
                vcnt_d   = '0;
                state_d  = (num_vec_q == '0) ? S_DRAIN : S_COMPUTE;
            end
            S_COMPUTE: begin
                inp_req = 1'b1;
                if (vcnt_q + VEC_W'(1) == num_vec_q) begin
                    state_d = S_DRAIN;
                end else begin
                    vcnt_d = vcnt_q + VEC_W'(1);
                end
            end
            S_DRAIN: begin
                if (pipe_empty) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pv_q <= '0;
            for (int i = 0; i <= PIPE_LAT; i++) begin
                pidx_q[i] <= '0;
            end
        end else begin
            pv_q      <= {pv_q[PIPE_LAT-1:0], inp_req};
            pidx_q[0] <= inp_req ? vcnt_q : '0;
            for (int i = 1; i <= PIPE_LAT; i++) begin
                pidx_q[i] <= pidx_q[i-1];
            end
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done;
    assign bus.wgt_rd_req  = wgt_req;
    assign bus.wgt_rd_addr = wgt_req ? wgt_base_q + ADDR_W'(wcnt_q) : '0;
    assign bus.inp_rd_req  = inp_req;
    assign bus.inp_rd_addr = inp_req ? inp_base_q + ADDR_W'(vcnt_q) : '0;
    assign bus.b_path_en   = {ARRAY_M{shift_en}};
    assign bus.b_en        = {ARRAY_M{b_en_q}};
    assign bus.out_valid   = pv_q[PIPE_LAT];
    assign bus.out_idx     = pidx_q[PIPE_LAT];
    assign bus.dbg_state   = state_q;

    // Committing while a shift is still in progress would latch a half-loaded weight column.
    a_no_shift_commit_overlap: assert property (@(posedge clk) disable iff (reset)
        !(b_en_q && shift_en));

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Self-checking bench for systolic_array_ctrl: per-job timeline model, per-cycle compare
// and directed job scenarios with hand-computed expectations.
module tb_systolic_array_ctrl;
    localparam int M        = 4;
    localparam int N        = 4;
    localparam int AW       = 10;
    localparam int VW       = 10;
    localparam int PL       = 8;
    localparam int DEPTH    = 4096;
    localparam int ALL_ROWS = (1 << M) - 1;
    localparam int AMASK    = (1 << AW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_array_ctrl_if #(.ARRAY_M(M), .ADDR_W(AW), .VEC_W(VW)) bus ();

    systolic_array_ctrl #(
        .ARRAY_M(M), .ARRAY_N(N), .ADDR_W(AW), .VEC_W(VW), .PIPE_LAT(PL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- expected timeline, indexed by cycle ----------------
    bit e_busy [DEPTH];
    bit e_done [DEPTH];
    bit e_wreq [DEPTH];
    bit e_ireq [DEPTH];
    bit e_bpe  [DEPTH];
    bit e_ben  [DEPTH];
    bit e_ov   [DEPTH];
    int e_waddr[DEPTH];
    int e_iaddr[DEPTH];
    int e_oidx [DEPTH];
    int free_at = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    endtask

    // Start seen in cycle c: M weight reads from c+1, shifts one cycle behind them, commit
    // with the first compute cycle, each result PL+1 cycles after its read, done once empty.
    function automatic void schedule_job(input int c, input int wb, input int ib, input int nv);
        int t0;
        int t_done;
        t0     = c + 1;
        t_done = (nv == 0) ? t0 + M + 1 : t0 + M + 1 + nv + PL + 1;
        for (int k = 0; k < M; k++) begin
            e_wreq[t0+k]  = 1'b1;
            e_waddr[t0+k] = (wb + k) & AMASK;
        end
        for (int k = 1; k <= M; k++) e_bpe[t0+k] = 1'b1;
        e_ben[t0+M+1] = 1'b1;
        for (int j = 0; j < nv; j++) begin
            e_ireq[t0+M+1+j]        = 1'b1;
            e_iaddr[t0+M+1+j]       = (ib + j) & AMASK;
            e_ov[t0+M+1+j+PL+1]     = 1'b1;
            e_oidx[t0+M+1+j+PL+1]   = j;
        end
        for (int t = t0; t <= t_done; t++) e_busy[t] = 1'b1;
        e_done[t_done] = 1'b1;
        free_at        = t_done + 1;
    endfunction

    function automatic void model_reset(input int r);
        for (int t = r + 1; t < DEPTH; t++) begin
            e_busy[t] = 1'b0; e_done[t] = 1'b0; e_wreq[t] = 1'b0; e_ireq[t] = 1'b0;
            e_bpe[t]  = 1'b0; e_ben[t]  = 1'b0; e_ov[t]   = 1'b0;
            e_waddr[t] = 0;   e_iaddr[t] = 0;   e_oidx[t] = 0;
        end
        free_at = r + 1;
    endfunction

    // ---------------- monitors ----------------
    int cnt_wreq, cnt_ireq, cnt_bpe, cnt_ben, cnt_ov, cnt_done;
    int first_ireq, first_ov;
    int obs_waddr[$];
    int obs_iaddr[$];
    int obs_idx[$];

    task automatic clear_mon();
        cnt_wreq = 0; cnt_ireq = 0; cnt_bpe = 0; cnt_ben = 0; cnt_ov = 0; cnt_done = 0;
        first_ireq = -1; first_ov = -1;
        obs_waddr.delete(); obs_iaddr.delete(); obs_idx.delete();
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < DEPTH) begin
            chk("busy",       int'(bus.busy),       int'(e_busy[cyc]));
            chk("done",       int'(bus.done),       int'(e_done[cyc]));
            chk("wgt_rd_req", int'(bus.wgt_rd_req), int'(e_wreq[cyc]));
            chk("inp_rd_req", int'(bus.inp_rd_req), int'(e_ireq[cyc]));
            chk("b_path_en",  int'(bus.b_path_en),  e_bpe[cyc] ? ALL_ROWS : 0);
            chk("b_en",       int'(bus.b_en),       e_ben[cyc] ? ALL_ROWS : 0);
            chk("out_valid",  int'(bus.out_valid),  int'(e_ov[cyc]));
            if (e_wreq[cyc]) chk("wgt_rd_addr", int'(bus.wgt_rd_addr), e_waddr[cyc]);
            if (e_ireq[cyc]) chk("inp_rd_addr", int'(bus.inp_rd_addr), e_iaddr[cyc]);
            if (e_ov[cyc])   chk("out_idx",     int'(bus.out_idx),     e_oidx[cyc]);

            if (bus.wgt_rd_req) begin cnt_wreq++; obs_waddr.push_back(int'(bus.wgt_rd_addr)); end
            if (bus.inp_rd_req) begin
                cnt_ireq++; obs_iaddr.push_back(int'(bus.inp_rd_addr));
                if (first_ireq < 0) first_ireq = cyc;
            end
            if (|bus.b_path_en) cnt_bpe++;
            if (|bus.b_en)      cnt_ben++;
            if (bus.done)       cnt_done++;
            if (bus.out_valid) begin
                cnt_ov++; obs_idx.push_back(int'(bus.out_idx));
                if (first_ov < 0) first_ov = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int wb, input int ib, input int nv, output int c);
        c                = cyc;
        bus.cfg_start    = 1'b1;
        bus.cfg_wgt_base = AW'(wb);
        bus.cfg_inp_base = AW'(ib);
        bus.cfg_num_vec  = VW'(nv);
        if (cyc >= free_at && !reset) schedule_job(cyc, wb, ib, nv);
        tick();
        bus.cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        int n;
        n    = 0;
        dcyc = -1;
        while (bus.done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", int'(bus.done === 1'b1), 1);
        if (bus.done === 1'b1) dcyc = cyc;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},      int'(bus.busy),        0);
        chk({tag, "_done"},      int'(bus.done),        0);
        chk({tag, "_wgt_req"},   int'(bus.wgt_rd_req),  0);
        chk({tag, "_wgt_addr"},  int'(bus.wgt_rd_addr), 0);
        chk({tag, "_inp_req"},   int'(bus.inp_rd_req),  0);
        chk({tag, "_inp_addr"},  int'(bus.inp_rd_addr), 0);
        chk({tag, "_b_path_en"}, int'(bus.b_path_en),   0);
        chk({tag, "_b_en"},      int'(bus.b_en),        0);
        chk({tag, "_out_valid"}, int'(bus.out_valid),   0);
        chk({tag, "_out_idx"},   int'(bus.out_idx),     0);
    endtask

    logic [VW-1:0] exp_q[$];

    // ---------------- scenarios ----------------
    initial begin
        int c, c2, d, mism;
        bus.cfg_start    = 1'b0;
        bus.cfg_wgt_base = '0;
        bus.cfg_inp_base = '0;
        bus.cfg_num_vec  = '0;
        clear_mon();

        // clock / reset
        reset = 1'b1;
        repeat (3) tick();
        reset   = 1'b0;
        free_at = cyc;
        chk_en  = 1'b1;
        check_all_zero("reset");
        tick();

        // 1: basic job, num_vec=3
        clear_mon();
        pulse_start('h010, 'h020, 3, c);
        wait_done(200, d);
        tick();
        chk("t1_done_latency", d - c, 18);
        chk("t1_wgt_reads", cnt_wreq, 4);
        for (int k = 0; k < 4; k++) chk("t1_wgt_addr", obs_waddr[k], 'h010 + k);
        chk("t1_b_path_en_cycles", cnt_bpe, 4);
        chk("t1_b_en_cycles", cnt_ben, 1);
        chk("t1_inp_reads", cnt_ireq, 3);
        chk("t1_first_inp_after_start", first_ireq - c, 6);
        chk("t1_out_latency", first_ov - first_ireq, 9);
        chk("t1_out_count", obs_idx.size(), 3);
        for (int k = 0; k < 3; k++) chk("t1_out_idx", obs_idx[k], k);
        chk("t1_done_count", cnt_done, 1);
        chk("t1_busy_after", int'(bus.busy), 0);

        // 2: num_vec=0
        clear_mon();
        pulse_start('h055, 'h066, 0, c);
        wait_done(200, d);
        tick();
        chk("t2_done_latency", d - c, 6);
        chk("t2_wgt_reads", cnt_wreq, 4);
        chk("t2_b_path_en_cycles", cnt_bpe, 4);
        chk("t2_b_en_cycles", cnt_ben, 1);
        chk("t2_inp_reads", cnt_ireq, 0);
        chk("t2_out_valid", cnt_ov, 0);
        chk("t2_done_count", cnt_done, 1);

        // 3: address wrap
        clear_mon();
        pulse_start('h3FE, 'h3FF, 2, c);
        wait_done(200, d);
        tick();
        chk("t3_wgt_addr0", obs_waddr[0], 'h3FE);
        chk("t3_wgt_addr1", obs_waddr[1], 'h3FF);
        chk("t3_wgt_addr2", obs_waddr[2], 'h000);
        chk("t3_wgt_addr3", obs_waddr[3], 'h001);
        chk("t3_inp_addr0", obs_iaddr[0], 'h3FF);
        chk("t3_inp_addr1", obs_iaddr[1], 'h000);

        // 4: starts during COMPUTE and during done are dropped, next cycle is taken
        clear_mon();
        pulse_start('h100, 'h200, 5, c);
        repeat (6) tick();
        pulse_start('h300, 'h000, 2, c2);
        wait_done(200, d);
        pulse_start('h1F0, 'h000, 2, c2);
        pulse_start('h040, 'h080, 2, c2);
        chk("t4_restart_cycle", c2, d + 1);
        wait_done(200, d);
        tick();
        chk("t4_done_count", cnt_done, 2);
        chk("t4_wgt_reads", cnt_wreq, 8);
        chk("t4_job1_wgt_first", obs_waddr[0], 'h100);
        chk("t4_job1_wgt_last", obs_waddr[3], 'h103);
        chk("t4_job2_wgt_first", obs_waddr[4], 'h040);
        chk("t4_job2_wgt_last", obs_waddr[7], 'h043);
        chk("t4_job1_inp_first", obs_iaddr[0], 'h200);
        chk("t4_job2_inp_first", obs_iaddr[5], 'h080);
        chk("t4_out_count", cnt_ov, 7);

        // 5: reset after 2 of 5 reads
        clear_mon();
        pulse_start('h000, 'h010, 5, c);
        repeat (6) tick();
        reset = 1'b1;
        model_reset(cyc);
        tick();
        reset = 1'b0;
        check_all_zero("t5_after_reset");
        repeat (PL + 4) tick();
        chk("t5_inp_reads", cnt_ireq, 2);
        chk("t5_out_valid", cnt_ov, 0);
        chk("t5_done_count", cnt_done, 0);

        // 6: back-to-back num_vec=1 and num_vec=max
        clear_mon();
        exp_q.delete();
        exp_q.push_back('0);
        for (int j = 0; j < 1023; j++) exp_q.push_back(VW'(j));
        pulse_start('h007, 'h009, 1, c);
        wait_done(200, d);
        tick();
        pulse_start('h000, 'h3F0, 1023, c2);
        chk("t6_back_to_back", c2, d + 1);
        wait_done(2000, d);
        tick();
        chk("t6_inp_reads", cnt_ireq, 1024);
        chk("t6_out_count", obs_idx.size(), exp_q.size());
        mism = 0;
        for (int k = 0; k < obs_idx.size() && k < exp_q.size(); k++) begin
            if (obs_idx[k] != int'(exp_q[k])) mism++;
        end
        chk("t6_idx_order_mismatches", mism, 0);
        chk("t6_last_idx", obs_idx[obs_idx.size()-1], 1022);
        chk("t6_done_count", cnt_done, 2);

        repeat (2) tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
